e1_tx_liu_mc: RTL

E1_TX_LIU_MC -- requirements
Module: e1_tx_liu_mc

---
 rtl/e1_tx_liu_mc_pkg.sv | 21 ++
 rtl/e1_tx_liu_mc_ch.sv | 110 +++++++++++
 rtl/e1_tx_liu_mc.sv | 46 ++++
 3 files changed

// File: rtl/e1_tx_liu_mc_pkg.sv
// ============================================================================
// Module   : e1_tx_liu_mc_pkg
// Brief    : Shared bounds and reset levels for the multi-channel E1 TX LIU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package e1_tx_liu_mc_pkg;

  localparam int   c_n_ch_min   = 1;
  localparam int   c_n_ch_max   = 8;
  localparam int   c_cnt_w_min  = 4;
  localparam int   c_cnt_w_max  = 8;

  // Pad levels before the optional clock inversion is applied
  localparam logic c_rst_data   = 1'b0;
  localparam logic c_rst_clk    = 1'b0;

endpackage

`default_nettype wire

// File: rtl/e1_tx_liu_mc_ch.sv
// ============================================================================
// Module   : e1_tx_liu_ch
// Brief    : One E1 TX channel: bit-period tracking, clock shaping, pad regs.
//            Optional macro E1_TX_LIU_AIS_EN sends all-ones during underrun.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module e1_tx_liu_ch
  import e1_tx_liu_mc_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int CLK_INV = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_data,
  input  logic in_valid,
  input  logic ch_en,
  input  logic stat_clr,
  output logic pad_tx_data,
  output logic pad_tx_clk,
  output logic stat_underrun
);

  localparam logic [CNT_W-1:0] c_max     = '1;
  localparam logic [CNT_W-1:0] c_pre_max = c_max - 1'b1;
  localparam logic             c_inv     = (CLK_INV != 0);

  logic [CNT_W-1:0] r_nxt;
  logic [CNT_W-1:0] r_cur;
  logic             r_data;
  logic             r_flag;
  logic             r_armed;
  logic             r_pad_data;
  logic             r_pad_clk;

  logic w_sat;
  logic w_set;
  logic w_tx_clk;
  logic w_tx_data;

  // r_armed low means no strobe seen since enable: the period counter stays
  // at zero so the first bit after enable gets a single-cycle high phase.
  assign w_sat = r_armed && (r_nxt == c_max);
  assign w_set = r_armed && !in_valid && (r_nxt == c_pre_max);

`ifdef E1_TX_LIU_AIS_EN
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_ais;

  assign w_tx_clk  = w_sat ? (r_ais <= (r_per >> 1)) : r_cur[CNT_W-1];
  assign w_tx_data = w_sat | r_data;

  // Free-running substitute clock at the last measured period
  always_ff @(posedge clk) begin
    if (rst || !ch_en) begin
      r_per <= '0;
      r_ais <= '0;
    end else begin
      if (in_valid) r_per <= r_nxt;
      if (!w_sat || (r_ais == r_per)) r_ais <= '0;
      else                            r_ais <= r_ais + 1'b1;
    end
  end
`else
  assign w_tx_clk  = r_cur[CNT_W-1] & ~w_sat;
  assign w_tx_data = r_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nxt      <= '0;
      r_cur      <= '0;
      r_data     <= c_rst_data;
      r_flag     <= 1'b0;
      r_armed    <= 1'b1;
      r_pad_data <= c_rst_data;
      r_pad_clk  <= c_rst_clk ^ c_inv;
    end else if (!ch_en) begin
      r_nxt      <= '0;
      r_cur      <= '0;
      r_data     <= c_rst_data;
      r_armed    <= 1'b0;
      r_pad_data <= c_rst_data;
      r_pad_clk  <= c_rst_clk ^ c_inv;
    end else begin
      if (in_valid) begin
        r_nxt   <= '0;
        r_cur   <= {1'b1, r_nxt[CNT_W-1:1]};
        r_data  <= in_data;
        r_armed <= 1'b1;
      end else begin
        if (r_armed && !w_sat) r_nxt <= r_nxt + 1'b1;
        if (r_cur != '0)       r_cur <= r_cur - 1'b1;
      end
      if (w_set)         r_flag <= 1'b1;
      else if (stat_clr) r_flag <= 1'b0;
      r_pad_data <= w_tx_data;
      r_pad_clk  <= w_tx_clk ^ c_inv;
    end
  end

  assign pad_tx_data   = r_pad_data;
  assign pad_tx_clk    = r_pad_clk;
  assign stat_underrun = r_flag;

endmodule

`default_nettype wire

// File: rtl/e1_tx_liu_mc.sv
// ============================================================================
// Module   : e1_tx_liu_mc
// Brief    : N_CH independent E1 TX channels driving an external LIU.
//            Optional macro E1_TX_LIU_AIS_EN enables AIS on underrun.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module e1_tx_liu_mc
  import e1_tx_liu_mc_pkg::*;
#(
  parameter int N_CH    = 1,
  parameter int CNT_W   = 6,
  parameter int CLK_INV = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [N_CH-1:0] pad_tx_data,
  output logic [N_CH-1:0] pad_tx_clk,
  input  logic [N_CH-1:0] in_data,
  input  logic [N_CH-1:0] in_valid,
  input  logic [N_CH-1:0] ch_en,
  output logic [N_CH-1:0] stat_underrun,
  input  logic [N_CH-1:0] stat_clr
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    e1_tx_liu_ch #(
      .CNT_W   (CNT_W),
      .CLK_INV (CLK_INV)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .in_data       (in_data[gi]),
      .in_valid      (in_valid[gi]),
      .ch_en         (ch_en[gi]),
      .stat_clr      (stat_clr[gi]),
      .pad_tx_data   (pad_tx_data[gi]),
      .pad_tx_clk    (pad_tx_clk[gi]),
      .stat_underrun (stat_underrun[gi])
    );
  end

endmodule

`default_nettype wire
